// File: rtl/rv32i_return_stack.sv
// rv32i_return_stack: circular return-address stack advanced by the decode strobe
module rv32i_return_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       data_ready_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [XLEN-1:0]            push_addr_i,
    output logic [XLEN-1:0]            pop_addr_o,
    output logic                       pop_valid_o,
    output logic [XLEN-1:0]            top_o,
    output logic                       top_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL = DEPTH[PTR_BITS:0];

    logic [XLEN-1:0]     mem [DEPTH];
    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] ptr_inc;
    logic [PTR_BITS-1:0] wr_idx;
    logic [PTR_BITS:0]   count;
    logic                empty;
    logic                go;
    logic                do_push;
    logic                do_pop;
    logic                do_swap;
    logic                wr_en;

    // Decode the request: an empty-stack swap degrades to a plain push.
    always_comb begin
        empty   = count == '0;
        ptr_inc = ptr + 1'b1;
        go      = data_ready_i & ~clear_i;
        do_push = go & push_i & (~pop_i | empty);
        do_pop  = go & pop_i & ~push_i & ~empty;
        do_swap = go & pop_i & push_i & ~empty;
        wr_en   = do_push | do_swap;
        wr_idx  = do_swap ? ptr : ptr_inc;
    end

    // Entry storage is never reset; only the pointer and occupancy are.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_idx] <= push_addr_i;
    end

    // Pointer, occupancy and the registered pop/pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr         <= '0;
            count       <= '0;
            pop_addr_o  <= '0;
            pop_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            pop_valid_o <= do_pop | do_swap;
            overflow_o  <= do_push & (count == FULL);
            underflow_o <= go & pop_i & empty;
            if (do_pop | do_swap) pop_addr_o <= mem[ptr];
            if (clear_i) begin
                ptr   <= '0;
                count <= '0;
            end else if (do_push) begin
                ptr   <= ptr_inc;
                count <= (count == FULL) ? count : count + 1'b1;
            end else if (do_pop) begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    assign top_o       = mem[ptr];
    assign top_valid_o = ~empty;
    assign count_o     = count;
endmodule

// File: tb/tb_rv32i_return_stack.sv
// tb_rv32i_return_stack: table-driven scoreboard bench for the return-address stack
module tb_rv32i_return_stack;
    typedef struct {
        logic        rst, clr, dr, push, pop;
        logic [31:0] addr;
        logic [3:0]  cnt;
        logic        tv;
        logic [31:0] top;
        logic        pv;
        logic [31:0] pa;
        logic        ov, un;
    } vec_t;

    logic        clk = 0;
    logic        rst = 0, clr = 0, dr = 0, push = 0, pop = 0;
    logic [31:0] push_addr = 0;
    logic [31:0] pop_addr, top;
    logic        pop_valid, top_valid, overflow, underflow;
    logic [3:0]  count;

    vec_t tbl[$];
    vec_t sb[$];
    int   applied = 0;
    int   miscompares = 0;

    rv32i_return_stack dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .data_ready_i(dr),
        .push_i(push), .pop_i(pop), .push_addr_i(push_addr),
        .pop_addr_o(pop_addr), .pop_valid_o(pop_valid),
        .top_o(top), .top_valid_o(top_valid), .count_o(count),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, c, d, pu, po, input logic [31:0] a,
                     input logic [3:0] cnt, input logic tv, input logic [31:0] tp,
                     input logic pv, input logic [31:0] pa, input logic ov, un);
        vec_t x;
        x.rst = r; x.clr = c; x.dr = d; x.push = pu; x.pop = po; x.addr = a;
        x.cnt = cnt; x.tv = tv; x.top = tp; x.pv = pv; x.pa = pa; x.ov = ov; x.un = un;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp, input int idx);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    initial begin
        // rst clr dr push pop addr | cnt tv top pv pa ov un
        v(1,0,0,0,0,32'h0,   0,0,32'h0,  0,32'h0,  0,0);
        v(0,0,1,1,0,32'h100, 1,1,32'h100,0,32'h0,  0,0);
        v(0,0,1,1,0,32'h200, 2,1,32'h200,0,32'h0,  0,0);
        v(0,0,1,1,0,32'h300, 3,1,32'h300,0,32'h0,  0,0);
        v(0,0,1,0,1,32'h0,   2,1,32'h200,1,32'h300,0,0);
        v(0,0,1,1,0,32'h300, 3,1,32'h300,0,32'h300,0,0);
        v(0,0,1,1,1,32'h400, 3,1,32'h400,1,32'h300,0,0);
        v(0,0,0,1,0,32'h500, 3,1,32'h400,0,32'h300,0,0);
        v(0,0,0,0,1,32'h0,   3,1,32'h400,0,32'h300,0,0);
        v(0,1,1,1,0,32'h600, 0,0,32'h0,  0,32'h300,0,0);
        v(0,0,1,0,1,32'h0,   0,0,32'h0,  0,32'h300,0,1);
        v(0,0,1,1,1,32'h700, 1,1,32'h700,0,32'h300,0,1);
        v(0,0,1,0,1,32'h0,   0,0,32'h0,  1,32'h700,0,0);
        v(0,0,1,1,0,32'h800, 1,1,32'h800,0,32'h700,0,0);
        v(0,0,1,1,0,32'h900, 2,1,32'h900,0,32'h700,0,0);
        v(1,0,1,1,1,32'hA00, 0,0,32'h0,  0,32'h0,  0,0);
        for (int i = 1; i <= 9; i++)
            v(0,0,1,1,0,32'(i*16), 4'((i > 8) ? 8 : i),1,32'(i*16),0,32'h0,(i == 9),0);
        for (int j = 0; j < 8; j++)
            v(0,0,1,0,1,32'h0, 4'(7-j),(j < 7),(j < 7) ? 32'(32'h80 - j*16) : 32'h0,
              1,32'(32'h90 - j*16),0,0);
        v(0,0,1,0,1,32'h0,   0,0,32'h0,  0,32'h20, 0,1);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst = tbl[k].rst; clr = tbl[k].clr; dr = tbl[k].dr;
            push = tbl[k].push; pop = tbl[k].pop; push_addr = tbl[k].addr;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            begin
                vec_t e;
                e = sb.pop_front();
                applied++;
                chk("count",     32'(count),     32'(e.cnt), k);
                chk("top_valid", 32'(top_valid), 32'(e.tv),  k);
                if (e.tv) chk("top", top, e.top, k);
                chk("pop_valid", 32'(pop_valid), 32'(e.pv),  k);
                chk("pop_addr",  pop_addr,       e.pa,       k);
                chk("overflow",  32'(overflow),  32'(e.ov),  k);
                chk("underflow", 32'(underflow), 32'(e.un),  k);
            end
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
